// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store front end and its lane-alignment logic.
package mem_access_unit_pkg;

    localparam int unsigned REG_WIDTH  = 32;
    localparam int unsigned BYTE_WIDTH = 8;
    localparam int unsigned HALF_WIDTH = 16;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } mau_state_e;

    // Encoding 3 is folded into a word access.
    function automatic mem_size_e norm_size(input logic [1:0] size);
        return (size == 2'd3) ? MEM_W : mem_size_e'(size);
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lane);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return lane[0];
            default: return (lane != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_size_e            size,
    input  logic                 sign_ext,
    input  logic [1:0]           lane,
    input  logic [REG_WIDTH-1:0] rword,
    input  logic [REG_WIDTH-1:0] wdata,
    output logic [REG_WIDTH-1:0] load_data_c,
    output logic [REG_WIDTH-1:0] merge_data_c
);

    logic [BYTE_WIDTH-1:0] byte_sel;
    logic [HALF_WIDTH-1:0] half_sel;

    always_comb begin
        byte_sel = rword[{lane, 3'b000} +: BYTE_WIDTH];
        half_sel = rword[{lane[1], 4'b0000} +: HALF_WIDTH];
    end

    always_comb begin
        load_data_c = rword;
        case (size)
            MEM_B:   load_data_c = {{(REG_WIDTH - BYTE_WIDTH){sign_ext & byte_sel[BYTE_WIDTH-1]}}, byte_sel};
            MEM_H:   load_data_c = {{(REG_WIDTH - HALF_WIDTH){sign_ext & half_sel[HALF_WIDTH-1]}}, half_sel};
            default: load_data_c = rword;
        endcase
    end

    // Unselected lanes of the read word are preserved.
    always_comb begin
        merge_data_c = rword;
        case (size)
            MEM_B:   merge_data_c[{lane, 3'b000} +: BYTE_WIDTH]    = wdata[BYTE_WIDTH-1:0];
            MEM_H:   merge_data_c[{lane[1], 4'b0000} +: HALF_WIDTH] = wdata[HALF_WIDTH-1:0];
            default: merge_data_c = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: byte/half/word requests to word-wide BRAM accesses,
// with read-modify-write for sub-word stores and misalignment reporting.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [REG_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [REG_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 mem_read_req,
    output logic [REG_WIDTH-1:0] mem_addr,
    output logic                 mem_write_ena,
    output logic [REG_WIDTH-1:0] mem_write_data,
    input  logic [REG_WIDTH-1:0] mem_read_data,
    input  logic                 mem_read_valid
);

    mau_state_e state, next_state;

    logic                 we_q;
    mem_size_e            size_q;
    logic                 sgn_q;
    logic [1:0]           lane_q;
    logic [REG_WIDTH-1:0] wdata_q;

    logic                 handshake_c;
    mem_size_e            req_size_c;
    logic                 misaligned_c;
    logic [REG_WIDTH-1:0] load_data_c;
    logic [REG_WIDTH-1:0] merge_data_c;

    logic                 req_ready_d;
    logic                 resp_valid_d;
    logic [REG_WIDTH-1:0] resp_rdata_d;
    logic                 resp_err_d;
    logic                 mem_read_req_d;
    logic [REG_WIDTH-1:0] mem_addr_d;
    logic                 mem_write_ena_d;
    logic [REG_WIDTH-1:0] mem_write_data_d;

    always_comb begin
        handshake_c  = req_valid & req_ready;
        req_size_c   = norm_size(req_size);
        misaligned_c = is_misaligned(req_size_c, req_addr[1:0]);
    end

    mem_lane_align u_lane_align (
        .size         (size_q),
        .sign_ext     (sgn_q),
        .lane         (lane_q),
        .rword        (mem_read_data),
        .wdata        (wdata_q),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (handshake_c) begin
                    if (misaligned_c)                       next_state = RESP;
                    else if (req_we && req_size_c == MEM_W) next_state = WRITE;
                    else                                    next_state = READ;
                end
            end
            READ:    next_state = WAIT;
            WAIT:    if (mem_read_valid) next_state = we_q ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        req_ready_d      = (next_state == IDLE);
        resp_valid_d     = (next_state == RESP);
        mem_read_req_d   = (next_state == READ);
        mem_write_ena_d  = (next_state == WRITE);
        resp_err_d       = (state == IDLE) && (next_state == RESP);
        resp_rdata_d     = resp_rdata;
        mem_addr_d       = mem_addr;
        mem_write_data_d = mem_write_data;
        case (state)
            IDLE: begin
                if (handshake_c) begin
                    resp_rdata_d     = '0;
                    mem_addr_d       = {2'b00, req_addr[REG_WIDTH-1:2]};
                    mem_write_data_d = req_wdata;
                end
            end
            WAIT: begin
                if (mem_read_valid) begin
                    if (we_q) mem_write_data_d = merge_data_c;
                    else      resp_rdata_d     = load_data_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_read_req   <= 1'b0;
            mem_addr       <= '0;
            mem_write_ena  <= 1'b0;
            mem_write_data <= '0;
        end else begin
            req_ready      <= req_ready_d;
            resp_valid     <= resp_valid_d;
            resp_rdata     <= resp_rdata_d;
            resp_err       <= resp_err_d;
            mem_read_req   <= mem_read_req_d;
            mem_addr       <= mem_addr_d;
            mem_write_ena  <= mem_write_ena_d;
            mem_write_data <= mem_write_data_d;
        end
    end

    // Request attributes held for the lane logic during WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= MEM_B;
            sgn_q   <= 1'b0;
            lane_q  <= 2'd0;
            wdata_q <= '0;
        end else if (handshake_c) begin
            we_q    <= req_we;
            size_q  <= req_size_c;
            sgn_q   <= req_signed;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end for one CPU memory port, sitting directly upstream of `bram_control`. It accepts byte, halfword and word requests over a valid/ready handshake and converts them into word-wide BRAM accesses. The BRAM word interface has a single write enable per port, so sub-word stores are performed as read-modify-write. Load data is sign- or zero-extended, misaligned requests are flagged, and each request completes with a one-cycle response pulse. One instance is placed per BRAM port (instruction side, data side).

## Interface
- No parameters; widths come from `REG_WIDTH` and `bool` in `defines.svh`.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  bool  request present.
- req_ready  out  bool  unit can accept; high only in IDLE.
- req_we  in  bool  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_signed  in  bool  sign-extend load result.
- req_addr  in  REG_WIDTH  byte address.
- req_wdata  in  REG_WIDTH  store data, right-aligned.
- resp_valid  out  bool  one-cycle completion pulse.
- resp_rdata  out  REG_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  bool  misaligned request; valid with resp_valid.
- mem_read_req  out  bool  one-cycle read request to BRAM.
- mem_addr  out  REG_WIDTH  word address, `{2'b0, req_addr[31:2]}`.
- mem_write_ena  out  bool  one-cycle word write.
- mem_write_data  out  REG_WIDTH  full word to write.
- mem_read_data  in  REG_WIDTH  BRAM read word.
- mem_read_valid  in  bool  BRAM read data valid.

## Operation
- FSM states: IDLE, READ, WAIT, WRITE, RESP. All outputs are registered.
- IDLE: req_ready=1. On a handshake, the unit latches the request and mem_addr, then transitions:
  - misaligned (half with addr[0]=1, or word with addr[1:0]≠0): to RESP with err=1.
  - word store: to WRITE.
  - otherwise: to READ.
- READ: mem_read_req=1 for exactly this cycle, then to WAIT.
- WAIT: mem_addr is held. The unit waits on mem_read_valid with no timeout. On valid:
  - load: latch the extracted and extended data, then to RESP.
  - sub-word store: latch the merged word, then to WRITE.
- WRITE: mem_write_ena=1 with mem_write_data, then to RESP.
- RESP: resp_valid=1, then to IDLE.
- Byte order is little-endian.
  - Byte lane = addr[1:0]; byte k is data[8k+7:8k].
  - Half lane = addr[1]; lane h is data[16h+15:16h].
- Load extension: bit 7 (byte) or bit 15 (half) is replicated when req_signed=1, zeros otherwise. Word loads pass the word through unchanged.
- Store merge: the low byte or half of req_wdata replaces the selected lane of the read word; other lanes are preserved.
- mem_read_valid is ignored outside WAIT.
- The memory write is always the last memory action of a request.

## Timing
- Reset values: state=IDLE, req_ready=1, all other outputs 0.
- Cycle 0 is the handshake edge.
- Word store: mem_write_ena in cycle 1, resp_valid in cycle 2.
- Misaligned request: resp_valid with resp_err in cycle 1; no memory activity.
- Load / sub-word store: mem_read_req in cycle 1. With `bram_control`, mem_read_valid arrives in cycle 3.
  - Load: resp_valid one cycle after mem_read_valid is sampled (cycle 4).
  - Sub-word store: mem_write_ena the cycle after mem_read_valid, resp_valid the cycle after that.
- Throughput: the next handshake is possible in the cycle after resp_valid. req_ready is low from cycle 1 through the RESP cycle.
- Reset mid-operation: outputs clear immediately and the request is abandoned with no response. Because the write comes last, memory is never partially modified.

## Structure
- Shared package:
  - `mem_size_e` enum: MEM_B=0, MEM_H=1, MEM_W=2.
  - `mau_state_e` enum.
- Sub-module `mem_lane_align` (combinational) provides load extract/extend and store merge, so the same logic can be reused by the instruction-side instance.

## Test plan
BRAM word at byte address 0x40 is preloaded with 0x8844_22F0.
- lb signed @0x40 -> resp_rdata 0xFFFF_FFF0; lbu @0x43 -> 0x0000_0088; exactly one mem_read_req each.
- lh signed @0x42 -> 0xFFFF_8844; lhu @0x42 -> 0x0000_8844; lw @0x40 -> 0x8844_22F0.
- sb @0x41 with wdata 0x1234_56AB:
  - one read, then mem_write_ena for one cycle with 0x8844_ABF0;
  - a following lw @0x40 returns 0x8844_ABF0.
- sw @0x44 with 0xDEAD_BEEF:
  - no mem_read_req, mem_write_ena in cycle 1, resp_valid in cycle 2;
  - mem_addr = 0x11.
- lw @0x42 and lh @0x41 -> resp_err=1 and resp_rdata=0 in cycle 1; no mem_read_req or mem_write_ena.
- Assert rst during WAIT of sh @0x40:
  - outputs 0 immediately and memory stays 0x8844_22F0;
  - after release, the next lbu @0x40 returns 0x0000_00F0.
